// File: rtl/requan_mult_arbiter_pkg.sv
// Shared Q2.14 constants, lock FSM encoding and the product requantizer
// used by the multiplier arbiter.
package requan_mult_arbiter_pkg;

   localparam int          FRAC_BITS = 14;
   localparam logic [15:0] SAT_POS   = 16'h7FFF;
   localparam logic [15:0] SAT_NEG   = 16'h8000;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // prod_hi is mult_p[35:14]; the result fits only when bits [35:29] agree.
   function automatic logic [15:0] requant(input logic [21:0] prod_hi, input logic sat);
      logic fits;
      fits = (&prod_hi[21:15]) || !(|prod_hi[21:15]);
      if (sat && !fits) begin
         return prod_hi[21] ? SAT_NEG : SAT_POS;
      end
      return prod_hi[15:0];
   endfunction

endpackage

// File: rtl/requan_mult_arbiter_if.sv
// Requester-side bundle of the shared multiplier arbiter: operand
// handshake plus the broadcast response.
interface requan_mult_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_lock;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [15:0]           resp_data;
   logic                  busy;

   modport master (
      output req_valid, req_lock, req_a, req_b,
      input  req_ready, resp_valid, resp_data, busy
   );

   modport slave (
      input  req_valid, req_lock, req_a, req_b,
      output req_ready, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/requan_mult_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping, returned one-hot.
module rr_priority_pick #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);

   logic found;
   int   idx;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/requan_mult_arbiter.sv
// Round-robin arbiter with locked bursts in front of the shared Q2.14
// requantizer multiplier; two-stage pipeline from accept to response.
module requan_mult_arbiter
   import requan_mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int MAX_BURST = 8,
   parameter int SATURATE  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   requan_mult_arbiter_if.slave  bus,
   output logic [15:0]           mult_a,
   output logic [15:0]           mult_b,
   input  logic [35:0]           mult_p
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   lock_state_e        state_q;
   logic [PW-1:0]      owner_q;
   logic [BW-1:0]      burst_cnt_q;
   logic [PW-1:0]      rr_ptr_q;

   logic [15:0]        mult_a_q, mult_b_q;
   logic               s1_valid_q;
   logic [PW-1:0]      s1_tag_q;
   logic [NUM_REQ-1:0] resp_valid_q;
   logic [15:0]        resp_data_q;

   logic [NUM_REQ-1:0] rr_grant;
   logic [NUM_REQ-1:0] grant;
   logic               owner_hold;
   logic               accept;
   logic [PW-1:0]      grant_idx;
   logic [PW-1:0]      rr_next;
   logic [15:0]        op_a_d, op_b_d;
   logic [15:0]        resp_data_d;
   logic [NUM_REQ-1:0] tag_onehot;
   logic               unused_frac;

   rr_priority_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (rr_grant)
   );

   // The owner keeps the port only while it is still asking, still locked and under budget.
   assign owner_hold = (state_q == LOCKED) && bus.req_valid[owner_q] &&
                       bus.req_lock[owner_q] && (burst_cnt_q < BW'(MAX_BURST));

   assign grant  = !reset_n   ? '0 :
                   owner_hold ? (NUM_REQ'(1) << owner_q) : rr_grant;
   assign accept = |grant;

   always_comb begin
      op_a_d    = '0;
      op_b_d    = '0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            op_a_d    = bus.req_a[16*i +: 16];
            op_b_d    = bus.req_b[16*i +: 16];
            grant_idx = PW'(i);
         end
      end
   end

   assign rr_next     = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   assign resp_data_d = requant(mult_p[35:FRAC_BITS], SATURATE != 0);
   assign tag_onehot  = NUM_REQ'(1) << s1_tag_q;
   assign unused_frac = ^mult_p[FRAC_BITS-1:0];

   // Burst grants leave rr_ptr alone; it already points past the owner from the locking grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         rr_ptr_q    <= '0;
      end else if (owner_hold) begin
         burst_cnt_q <= burst_cnt_q + 1'b1;
      end else if (accept) begin
         rr_ptr_q <= rr_next;
         if (bus.req_lock[grant_idx]) begin
            state_q     <= LOCKED;
            owner_q     <= grant_idx;
            burst_cnt_q <= BW'(1);
         end else begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
         end
      end else begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_tag_q     <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            mult_a_q <= op_a_d;
            mult_b_q <= op_b_d;
            s1_tag_q <= grant_idx;
         end
         resp_valid_q <= s1_valid_q ? tag_onehot : '0;
         if (s1_valid_q) begin
            resp_data_q <= resp_data_d;
         end
      end
   end

   assign bus.req_ready  = grant;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.busy       = s1_valid_q || (|resp_valid_q);
   assign mult_a         = mult_a_q;
   assign mult_b         = mult_b_q;

endmodule

// File: tb/tb_requan_mult_arbiter.sv
// Directed bench for requan_mult_arbiter: one saturating and one wrapping
// instance, each fed by a behavioural 16x16 signed multiplier.
module tb_requan_mult_arbiter;

   logic        clk;
   logic        reset_n;
   logic [15:0] m0a, m0b, m1a, m1b;
   logic [35:0] m0p, m1p;
   int          errors;
   int          checks;

   requan_mult_arbiter_if #(.NUM_REQ(3)) bus0 ();
   requan_mult_arbiter_if #(.NUM_REQ(3)) bus1 ();

   requan_mult_arbiter #(.NUM_REQ(3), .MAX_BURST(8), .SATURATE(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0),
      .mult_a  (m0a),
      .mult_b  (m0b),
      .mult_p  (m0p)
   );

   requan_mult_arbiter #(.NUM_REQ(3), .MAX_BURST(8), .SATURATE(0)) dut_wrap (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1),
      .mult_a  (m1a),
      .mult_b  (m1b),
      .mult_p  (m1p)
   );

   // External shared multiplier: full sign-extended product.
   assign m0p = $signed({{20{m0a[15]}}, m0a}) * $signed({{20{m0b[15]}}, m0b});
   assign m1p = $signed({{20{m1a[15]}}, m1a}) * $signed({{20{m1b[15]}}, m1b});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus0.req_valid = '0; bus0.req_lock = '0; bus0.req_a = '0; bus0.req_b = '0;
      bus1.req_valid = '0; bus1.req_lock = '0; bus1.req_a = '0; bus1.req_b = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      checks++;
      if (bus0.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", bus0.req_ready); end
      checks++;
      if (bus0.resp_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 000", bus0.resp_valid); end
      checks++;
      if (bus0.resp_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 0000", bus0.resp_data); end
      checks++;
      if (m0a !== 16'h0000 || m0b !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mult_ops: got %h/%h expected 0000/0000", m0a, m0b); end
      checks++;
      if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus0.busy); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_op();
      do_reset();
      bus0.req_a[15:0] = 16'h4000; bus0.req_b[15:0] = 16'h4000; bus0.req_valid = 3'b001;
      #1 checks++;
      if (bus0.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL single_ready: got %b expected 001", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b000;
      #1 checks++;
      if (bus0.resp_valid !== 3'b000 || bus0.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_stage1: got resp %b busy %b expected 000 1", bus0.resp_valid, bus0.busy); end
      checks++;
      if (m0a !== 16'h4000 || m0b !== 16'h4000) begin errors++; $display("[TB] FAIL single_mult_ops: got %h/%h expected 4000/4000", m0a, m0b); end
      @(negedge clk);
      #1 checks++;
      if (bus0.resp_valid !== 3'b001 || bus0.resp_data !== 16'h4000) begin errors++; $display("[TB] FAIL single_resp_pos: got %b %h expected 001 4000", bus0.resp_valid, bus0.resp_data); end
      @(negedge clk);
      bus0.req_a[15:0] = 16'hC000; bus0.req_valid = 3'b001;
      #1 checks++;
      if (bus0.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL single_ready_neg: got %b expected 001", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b000;
      @(negedge clk);
      #1 checks++;
      if (bus0.resp_valid !== 3'b001 || bus0.resp_data !== 16'hC000) begin errors++; $display("[TB] FAIL single_resp_neg: got %b %h expected 001 c000", bus0.resp_valid, bus0.resp_data); end
      @(negedge clk);
      #1 checks++;
      if (bus0.resp_valid !== 3'b000 || bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_strobe_end: got resp %b busy %b expected 000 0", bus0.resp_valid, bus0.busy); end
      @(negedge clk);
   endtask

   task automatic test_saturate();
      do_reset();
      bus0.req_a[15:0] = 16'h7FFF; bus0.req_b[15:0] = 16'h7FFF; bus0.req_valid = 3'b001;
      #1 checks++;
      if (bus0.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL sat_ready0: got %b expected 001", bus0.req_ready); end
      @(negedge clk);
      bus0.req_a[15:0] = 16'h8000;
      #1 checks++;
      if (bus0.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL sat_ready1: got %b expected 001", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b000;
      #1 checks++;
      if (bus0.resp_valid !== 3'b001 || bus0.resp_data !== 16'h7FFF) begin errors++; $display("[TB] FAIL sat_pos: got %b %h expected 001 7fff", bus0.resp_valid, bus0.resp_data); end
      @(negedge clk);
      #1 checks++;
      if (bus0.resp_valid !== 3'b001 || bus0.resp_data !== 16'h8000) begin errors++; $display("[TB] FAIL sat_neg: got %b %h expected 001 8000", bus0.resp_valid, bus0.resp_data); end
      @(negedge clk);
   endtask

   task automatic test_saturate_off();
      do_reset();
      bus1.req_a[15:0] = 16'h7FFF; bus1.req_b[15:0] = 16'h7FFF; bus1.req_valid = 3'b001;
      #1 checks++;
      if (bus1.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL wrap_ready: got %b expected 001", bus1.req_ready); end
      @(negedge clk);
      bus1.req_valid = 3'b000;
      @(negedge clk);
      #1 checks++;
      if (bus1.resp_valid !== 3'b001 || bus1.resp_data !== 16'hFFFC) begin errors++; $display("[TB] FAIL wrap_slice: got %b %h expected 001 fffc", bus1.resp_valid, bus1.resp_data); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [15:0] opa [3];
      logic [2:0]  exp;
      int          r;
      opa = '{16'h1000, 16'h2000, 16'h3000};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus0.req_a[16*i +: 16] = opa[i];
         bus0.req_b[16*i +: 16] = 16'h4000;
      end
      for (int c = 0; c < 8; c++) begin
         bus0.req_valid = (c < 6) ? 3'b111 : 3'b000;
         #1;
         if (c < 6) begin
            exp = 3'b001 << (c % 3);
            checks++;
            if (bus0.req_ready !== exp) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", c, bus0.req_ready, exp); end
         end
         if (c >= 2) begin
            r   = (c - 2) % 3;
            exp = 3'b001 << r;
            checks++;
            if (bus0.resp_valid !== exp || bus0.resp_data !== opa[r]) begin
               errors++;
               $display("[TB] FAIL rr_resp[%0d]: got %b %h expected %b %h", c, bus0.resp_valid, bus0.resp_data, exp, opa[r]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lock_burst();
      int         expg [12];
      logic [2:0] exp;
      expg = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 1, 1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus0.req_a[16*i +: 16] = 16'h0800;
         bus0.req_b[16*i +: 16] = 16'h4000;
      end
      bus0.req_lock = 3'b010;
      for (int c = 0; c < 12; c++) begin
         bus0.req_valid = (c == 0) ? 3'b010 : 3'b111;
         #1 exp = 3'b001 << expg[c];
         checks++;
         if (bus0.req_ready !== exp) begin errors++; $display("[TB] FAIL burst_grant[%0d]: got %b expected %b", c, bus0.req_ready, exp); end
         @(negedge clk);
      end
      bus0.req_valid = 3'b000;
      bus0.req_lock  = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_lock_drop();
      logic [2:0] vseq [4];
      int         expg [4];
      logic [2:0] exp;
      vseq = '{3'b100, 3'b101, 3'b001, 3'b101};
      expg = '{2, 2, 0, 2};
      do_reset();
      bus0.req_a[15:0]  = 16'h1000; bus0.req_b[15:0]  = 16'h4000;
      bus0.req_a[47:32] = 16'h2000; bus0.req_b[47:32] = 16'h4000;
      bus0.req_lock = 3'b100;
      for (int c = 0; c < 5; c++) begin
         if (c < 4) begin
            bus0.req_valid = vseq[c];
            #1 exp = 3'b001 << expg[c];
            checks++;
            if (bus0.req_ready !== exp) begin errors++; $display("[TB] FAIL drop_grant[%0d]: got %b expected %b", c, bus0.req_ready, exp); end
         end else begin
            bus0.req_valid = 3'b000;
            #1 checks++;
            if (bus0.resp_valid !== 3'b001 || bus0.resp_data !== 16'h1000) begin
               errors++;
               $display("[TB] FAIL drop_resp: got %b %h expected 001 1000", bus0.resp_valid, bus0.resp_data);
            end
         end
         @(negedge clk);
      end
      bus0.req_lock = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      bus0.req_a[15:0]  = 16'h1000; bus0.req_b[15:0]  = 16'h4000;
      bus0.req_a[31:16] = 16'h2000; bus0.req_b[31:16] = 16'h4000;
      bus0.req_valid = 3'b001;
      #1 checks++;
      if (bus0.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL arst_ready0: got %b expected 001", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b010;
      #1 checks++;
      if (bus0.req_ready !== 3'b010) begin errors++; $display("[TB] FAIL arst_ready1: got %b expected 010", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b110;
      #1 checks++;
      if (bus0.resp_valid !== 3'b001 || m0a !== 16'h2000) begin errors++; $display("[TB] FAIL arst_inflight: got %b %h expected 001 2000", bus0.resp_valid, m0a); end
      #1 reset_n = 1'b0;
      #1 checks++;
      if (bus0.req_ready !== 3'b000 || bus0.resp_valid !== 3'b000 || bus0.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arst_immediate: got ready %b resp %b busy %b expected 000 000 0", bus0.req_ready, bus0.resp_valid, bus0.busy);
      end
      checks++;
      if (m0a !== 16'h0000 || m0b !== 16'h0000 || bus0.resp_data !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL arst_data: got %h %h %h expected 0000 0000 0000", m0a, m0b, bus0.resp_data);
      end
      repeat (2) @(negedge clk);
      bus0.req_valid = 3'b000;
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 checks++;
         if (bus0.resp_valid !== 3'b000 || bus0.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_no_resp[%0d]: got %b busy %b expected 000 0", c, bus0.resp_valid, bus0.busy);
         end
         @(negedge clk);
      end
      bus0.req_valid = 3'b110;
      #1 checks++;
      if (bus0.req_ready !== 3'b010) begin errors++; $display("[TB] FAIL arst_first_grant: got %b expected 010", bus0.req_ready); end
      @(negedge clk);
      bus0.req_valid = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      $display("[TB] start");
      test_reset();
      test_single_op();
      test_saturate();
      test_saturate_off();
      test_round_robin();
      test_lock_burst();
      test_lock_drop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/requan_mult_arbiter.md
Name: requan_mult_arbiter

Overview:
- Shares the single 16x16 signed Q2.14 requantizer multiplier between NUM_REQ requesters: requantizer scale, stereo processing and antialias.
- Round-robin arbitration with an optional locked burst per requester.
- Registers operands into the multiplier, which is a combinational instance outside this block, then registers the scaled result back to the winning requester.
- Sits between the Huffman/requantizer datapath clients and the shared multiplier.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_BURST, 8, max consecutive grants to one locked requester before forced rotation
SATURATE, 1, 1 = clamp out-of-range products; 0 = plain bit slice [29:14]

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_lock  input  NUM_REQ  keep grant for back-to-back operations
req_a  input  16*NUM_REQ  packed signed operand A, requester i at [16i+15:16i]
req_b  input  16*NUM_REQ  packed signed operand B
req_ready  output  NUM_REQ  one-hot accept this cycle
resp_valid  output  NUM_REQ  one-hot result strobe
resp_data  output  16  result, shared by all requesters
mult_a  output  16  to shared multiplier operand A
mult_b  output  16  to shared multiplier operand B
mult_p  input  36  full product from shared multiplier, sign-extended 18x18
busy  output  1  any operation in flight

Behaviour:
- Reset (async, reset_n low): req_ready=0, resp_valid=0, resp_data=0, mult_a=0, mult_b=0, busy=0, rr_ptr=0, burst_cnt=0, owner=none. Clears all in-flight state immediately; an operation in flight is dropped and never responded.
- Handshake: transfer when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and arbiter state, at most one bit high. Requesters hold req_a/req_b stable while valid and not ready.
- Arbitration, one grant per cycle:
  - If owner locked (owner's req_lock=1, owner's req_valid=1, burst_cnt<MAX_BURST): grant owner.
  - Else grant the first valid requester searching from rr_ptr upward with wrap.
  - After any non-burst grant g: rr_ptr=(g+1) mod NUM_REQ.
- Lock FSM states IDLE, LOCKED:
  - IDLE->LOCKED on a grant with req_lock[g]=1; owner=g, burst_cnt=1.
  - LOCKED: each owner grant increments burst_cnt.
  - LOCKED->IDLE when owner drops req_lock, owner drops req_valid, or burst_cnt reaches MAX_BURST. The forced exit rotates rr_ptr past owner, so owner cannot re-win that cycle if others are valid.
  - LOCKED with owner idle for one cycle (valid=0): unlock; other requesters are granted that same cycle.
- Pipeline, throughput one op per cycle, latency 2:
  - Cycle 0: accept.
  - Cycle 1: mult_a/mult_b registered with operands; tag registered.
  - Cycle 2: resp_data/resp_valid[tag] registered from mult_p.
  - resp_valid is a single-cycle strobe. No response backpressure; requesters always accept.
- Arithmetic: result = mult_p[29:14], signed Q2.14.
  - SATURATE=1: if mult_p[35:29] not all equal, result = 0x7FFF when mult_p[35]=0, else 0x8000.
  - SATURATE=0: bare slice, wraps.
- busy=1 while any pipeline stage holds a valid op.
- No valid requesters: req_ready=0, pipeline drains, rr_ptr unchanged.
- Simultaneous accept and response in the same cycle is the normal case and is required to work.

Decomposition:
- Shared package: Q-format constants (FRAC_BITS=14, SAT_POS=16'h7FFF, SAT_NEG=16'h8000) and the lock FSM state encoding.
- One natural sub-module: rr_priority_pick, a combinational round-robin picker with req vector and pointer in, one-hot grant out. Also reusable for memory-port arbitration.

Test Plan:
- Single op, req 0: a=0x4000, b=0x4000 -> resp_valid[0] exactly 2 cycles after accept, resp_data=0x4000. a=0xC000, b=0x4000 -> 0xC000.
- Overflow: a=b=0x7FFF. SATURATE=1 -> 0x7FFF. SATURATE=0 -> 0xFFFC. a=0x8000, b=0x7FFF with SATURATE=1 -> 0x8000.
- All three requesting continuously, no lock -> grants 0,1,2,0,1,2, one per cycle. Responses tagged to match, with the 2-cycle offset.
- Req 1 locked and valid continuously, reqs 0 and 2 valid, MAX_BURST=8 -> 8 consecutive grants to 1, then 2, then 0. Req 1 then regains and locks again.
- Req 2 locked, then drops req_valid for one cycle while req 0 valid -> req 0 granted that same cycle, FSM returns to IDLE.
- reset_n pulsed low asynchronously with 2 ops in flight -> all outputs 0 immediately, no resp_valid after release. First grant after release goes to the lowest-index valid requester (rr_ptr=0).
